// File: rtl/baser_257b_pkg.sv
// Shared types and helpers for the 257b transcoded BASE-R receive monitor.
//  - lock_state_t / blk_class_t: per-lane lock FSM state and block classes.
//  - BT_LEGAL: legal 4-bit compressed block types for the first control block.
//  - ST_*: positions of the statistics counters in a lane's packed stats bus.
//  - classify_257b(): maps one 257b block to exactly one class.
// 257b layout when hdr (bit 0) is 0:
//  - bits[4:1] are per-64b flags, with flag s at bit 1+s (1 = data, 0 = control).
//  - bits[8:5] hold the type nibble of the first control sub-block.
//  - From bit 9 the sub-blocks follow in order. Data sub-blocks take 64 bits.
//  - The first control sub-block takes 56 bits, because its type byte was
//    compressed into bits[8:5]. Later control sub-blocks take 64 bits.
package baser_257b_pkg;

  localparam int TC_W = 257;

  typedef enum logic {HUNT, LOCKED} lock_state_t;

  typedef enum logic [2:0] {
    CLS_DATA,
    CLS_CTRL,
    CLS_INV_SH,
    CLS_INV_FMT,
    CLS_INV_PAT
  } blk_class_t;

  // High nibbles of 8'h1E,2D,33,4B,55,66,78,87,99,AA,B4,CC,D2,E1,FF; 4'h0 is illegal.
  localparam logic [3:0] BT_LEGAL [15] = '{
    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
    4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF
  };

  localparam int ST_BLOCK   = 0;
  localparam int ST_DATA    = 1;
  localparam int ST_CTRL    = 2;
  localparam int ST_INV_SH  = 3;
  localparam int ST_INV_PAT = 4;
  localparam int ST_INV_FMT = 5;
  localparam int ST_UNLOCK  = 6;
  localparam int NUM_STATS  = 7;

  function automatic logic bt_legal(input logic [3:0] t);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (t == BT_LEGAL[k]) ok = 1'b1;
    end
    return ok;
  endfunction

  // Priority: inv_sh > inv_format > inv_pattern > ctrl/data.
  function automatic blk_class_t classify_257b(input logic [TC_W-1:0] blk,
                                               input logic [7:0] pat);
    logic       pat_ok;
    logic       first_ctrl_seen;
    logic [8:0] p;
    blk_class_t cls;
    pat_ok          = 1'b1;
    first_ctrl_seen = 1'b0;
    if (blk[0]) begin
      p = 9'd1;
      for (int b = 0; b < 32; b++) begin
        if (blk[p +: 8] != pat) pat_ok = 1'b0;
        p = p + 9'd8;
      end
      cls = pat_ok ? CLS_DATA : CLS_INV_PAT;
    end else if (blk[4:1] == 4'hF) begin
      cls = CLS_INV_SH;
    end else if (!bt_legal(blk[8:5])) begin
      cls = CLS_INV_FMT;
    end else begin
      p = 9'd9;
      for (int s = 0; s < 4; s++) begin
        if (blk[1+s]) begin
          for (int b = 0; b < 8; b++) begin
            if (blk[p +: 8] != pat) pat_ok = 1'b0;
            p = p + 9'd8;
          end
        end else if (!first_ctrl_seen) begin
          first_ctrl_seen = 1'b1;
          p = p + 9'd56;
        end else begin
          p = p + 9'd64;
        end
      end
      cls = pat_ok ? CLS_CTRL : CLS_INV_PAT;
    end
    return cls;
  endfunction

endpackage

// File: rtl/baser_257b_lane_mon.sv
// One lane of the 257b monitor: block classifier, block-lock FSM, and
// saturating statistics counters.
// Ports:
//  clk, i_rst_n  clock, synchronous active-low reset
//  i_valid       i_blk carries a block this cycle
//  i_blk         257b transcoded block
//  i_clear       zero all statistics counters (FSM untouched)
//  o_lock        1 while the FSM is LOCKED (the FSM state itself)
//  o_stats       packed counters, counter k at [k*CNT_WIDTH +: CNT_WIDTH]
// i_valid qualifies the block. There is no backpressure: a block presented
// with i_valid high is consumed at that clock edge.
module baser_257b_lane_mon
  import baser_257b_pkg::*;
#(
  parameter int         TC_WIDTH          = 257,
  parameter int         CNT_WIDTH         = 32,
  parameter logic [7:0] DATA_CHAR_PATTERN = 8'hAA,
  parameter int         LOCK_GOOD         = 64,
  parameter int         WIN_LEN           = 1024,
  parameter int         UNLOCK_BAD        = 16
) (
  input  logic                           clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  input  logic [TC_WIDTH-1:0]            i_blk,
  input  logic                           i_clear,
  output logic                           o_lock,
  output logic [NUM_STATS*CNT_WIDTH-1:0] o_stats
);

  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int BW = $clog2(UNLOCK_BAD + 1);

  blk_class_t           cls;
  logic                 is_inv;
  lock_state_t          state_q, state_d;
  logic [GW-1:0]        good_q, good_d;
  logic [WW-1:0]        win_q, win_d;
  logic [BW-1:0]        bad_q, bad_d;
  logic                 unlock_evt;
  logic [NUM_STATS-1:0] inc;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_STATS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_STATS];

  always_comb begin
    cls    = classify_257b(i_blk, DATA_CHAR_PATTERN);
    is_inv = (cls == CLS_INV_SH) || (cls == CLS_INV_FMT) || (cls == CLS_INV_PAT);
  end

  // Lock FSM. In LOCKED, the unlock test runs before the window wrap, so a
  // bad block landing on the wrap cycle can still be the one that unlocks.
  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    win_d      = win_q;
    bad_d      = bad_q;
    unlock_evt = 1'b0;
    if (i_valid) begin
      case (state_q)
        HUNT: begin
          if (cls == CLS_INV_SH) begin
            good_d = '0;
          end else if (good_q == GW'(LOCK_GOOD - 1)) begin
            state_d = LOCKED;
            good_d  = '0;
            win_d   = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end
        LOCKED: begin
          if (is_inv && (bad_q == BW'(UNLOCK_BAD - 1))) begin
            state_d    = HUNT;
            good_d     = '0;
            win_d      = '0;
            bad_d      = '0;
            unlock_evt = 1'b1;
          end else if (win_q == WW'(WIN_LEN - 1)) begin
            win_d = '0;
            bad_d = '0;
          end else begin
            win_d = win_q + WW'(1);
            bad_d = is_inv ? bad_q + BW'(1) : bad_q;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Saturating counters; a clear wins over a coincident increment.
  always_comb begin
    inc             = '0;
    inc[ST_BLOCK]   = i_valid;
    inc[ST_DATA]    = i_valid && (cls == CLS_DATA);
    inc[ST_CTRL]    = i_valid && (cls == CLS_CTRL);
    inc[ST_INV_SH]  = i_valid && (cls == CLS_INV_SH);
    inc[ST_INV_PAT] = i_valid && (cls == CLS_INV_PAT);
    inc[ST_INV_FMT] = i_valid && (cls == CLS_INV_FMT);
    inc[ST_UNLOCK]  = unlock_evt;
    for (int k = 0; k < NUM_STATS; k++) begin
      if (i_clear) begin
        cnt_d[k] = '0;
      end else if (inc[k] && (cnt_q[k] != '1)) begin
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
      end else begin
        cnt_d[k] = cnt_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q <= HUNT;
      good_q  <= '0;
      win_q   <= '0;
      bad_q   <= '0;
      for (int k = 0; k < NUM_STATS; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      win_q   <= win_d;
      bad_q   <= bad_d;
      for (int k = 0; k < NUM_STATS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    o_lock = (state_q == LOCKED);
    for (int k = 0; k < NUM_STATS; k++) o_stats[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
  end

endmodule

// File: rtl/baser_257b_multilane_monitor.sv
// N-lane receive monitor for 257b transcoded BASE-R blocks.
// It runs one baser_257b_lane_mon per lane. This level holds only the lock
// AND and the registered lane-select readout mux.
// Ports:
//  clk, i_rst_n         clock, synchronous active-low reset
//  i_valid[n]           lane n carries a block
//  i_rx_xcoded          lane n at [n*TC_WIDTH +: TC_WIDTH]
//  i_clear              zero all statistics counters
//  i_lane_sel           lane whose counters appear on o_*_count one cycle later
//  o_lock, o_all_locked per-lane lock and their AND
//  o_*_count            selected lane's statistics (0 if i_lane_sel >= NUM_LANES)
// i_valid qualifies each lane's block. There is no backpressure: a block
// presented with i_valid high is consumed at that clock edge.
module baser_257b_multilane_monitor
  import baser_257b_pkg::*;
#(
  parameter int         NUM_LANES         = 4,
  parameter int         TC_WIDTH          = 257,
  parameter int         CNT_WIDTH         = 32,
  parameter logic [7:0] DATA_CHAR_PATTERN = 8'hAA,
  parameter int         LOCK_GOOD         = 64,
  parameter int         WIN_LEN           = 1024,
  parameter int         UNLOCK_BAD        = 16,
  localparam int        LSW               = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                          clk,
  input  logic                          i_rst_n,
  input  logic [NUM_LANES-1:0]          i_valid,
  input  logic [NUM_LANES*TC_WIDTH-1:0] i_rx_xcoded,
  input  logic                          i_clear,
  input  logic [LSW-1:0]                i_lane_sel,
  output logic [NUM_LANES-1:0]          o_lock,
  output logic                          o_all_locked,
  output logic [CNT_WIDTH-1:0]          o_block_count,
  output logic [CNT_WIDTH-1:0]          o_data_count,
  output logic [CNT_WIDTH-1:0]          o_ctrl_count,
  output logic [CNT_WIDTH-1:0]          o_inv_sh_count,
  output logic [CNT_WIDTH-1:0]          o_inv_pattern_count,
  output logic [CNT_WIDTH-1:0]          o_inv_format_count,
  output logic [CNT_WIDTH-1:0]          o_unlock_count
);

  logic [NUM_STATS*CNT_WIDTH-1:0] lane_stats [NUM_LANES];
  logic [NUM_STATS*CNT_WIDTH-1:0] rd_d, rd_q;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    baser_257b_lane_mon #(
      .TC_WIDTH          (TC_WIDTH),
      .CNT_WIDTH         (CNT_WIDTH),
      .DATA_CHAR_PATTERN (DATA_CHAR_PATTERN),
      .LOCK_GOOD         (LOCK_GOOD),
      .WIN_LEN           (WIN_LEN),
      .UNLOCK_BAD        (UNLOCK_BAD)
    ) u_lane (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid[n]),
      .i_blk   (i_rx_xcoded[n*TC_WIDTH +: TC_WIDTH]),
      .i_clear (i_clear),
      .o_lock  (o_lock[n]),
      .o_stats (lane_stats[n])
    );
  end

  // Out-of-range selects match no lane and present zero.
  always_comb begin
    rd_d = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      if (i_lane_sel == LSW'(n)) rd_d = lane_stats[n];
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) rd_q <= '0;
    else          rd_q <= rd_d;
  end

  assign o_all_locked        = &o_lock;
  assign o_block_count       = rd_q[ST_BLOCK*CNT_WIDTH   +: CNT_WIDTH];
  assign o_data_count        = rd_q[ST_DATA*CNT_WIDTH    +: CNT_WIDTH];
  assign o_ctrl_count        = rd_q[ST_CTRL*CNT_WIDTH    +: CNT_WIDTH];
  assign o_inv_sh_count      = rd_q[ST_INV_SH*CNT_WIDTH  +: CNT_WIDTH];
  assign o_inv_pattern_count = rd_q[ST_INV_PAT*CNT_WIDTH +: CNT_WIDTH];
  assign o_inv_format_count  = rd_q[ST_INV_FMT*CNT_WIDTH +: CNT_WIDTH];
  assign o_unlock_count      = rd_q[ST_UNLOCK*CNT_WIDTH  +: CNT_WIDTH];

endmodule
